page_qin_mchan: RTL and testbench
=================================

// Module: page_qin_mchan
// PURPOSE
//  Parametrised multi-channel page input queue; successor of the single-stream, fixed-width page qin.
//  NCH independent streams, each carrying {data, eos} tokens with valid/back-pressure handshake.
//  Sits between the inter-page network and a page's operator FSM. Per channel: DEPTH-entry FIFO,
//  early back-pressure with RESERVE slack, sticky overflow and eos-seen status.
// PARAMETERS
//  W        16  data width per token, excluding the eos bit
//  NCH       1  number of independent channels (1..16)
//  DEPTH     4  FIFO entries per channel (2..64; need not be a power of 2)
//  RESERVE   1  slack entries; busy raised while occupancy >= DEPTH-RESERVE (0..DEPTH-1)
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  qin_d      in   NCH*W  input data; channel c at [c*W +: W]
//  qin_e      in   NCH    input end-of-stream flag per channel
//  qin_v      in   NCH    input token valid per channel
//  qin_b      out  NCH    back-pressure (busy) to producer per channel
//  qout_d     out  NCH*W  head-of-queue data per channel
//  qout_e     out  NCH    head-of-queue eos flag per channel
//  qout_v     out  NCH    head-of-queue valid per channel
//  qout_b     in   NCH    back-pressure from consumer per channel
//  ovf        out  NCH    sticky overflow: token offered while full and not popping
//  eos_seen   out  NCH    sticky: a token with eos=1 has been dequeued
// BEHAVIOUR
//  - Reset (reset=0, async): pointers, counts, ovf, eos_seen cleared; qout_v=0, qin_b=0, ovf=0,
//    eos_seen=0; qout_d/qout_e=0. Reset mid-stream discards all queued tokens, no partial state kept.
//  - Channels fully independent; no cross-channel ordering or arbitration.
//  - push = qin_v & (count<DEPTH | pop). pop = qout_v & ~qout_b.
//  - Producer honours qin_b with one cycle of lag; tokens offered while qin_b=1 still accepted
//    if space remains (RESERVE absorbs in-flight tokens). qin_b is NOT an accept signal.
//  - qin_b = (count >= DEPTH-RESERVE), combinational from registered count. RESERVE=0: busy only when full.
//  - qout_v = (count != 0); qout_d/qout_e = entry at read pointer (combinational read of array).
//  - Latency: token pushed at edge N visible on qout at N+1 (empty-queue fall-through not supported).
//  - Simultaneous push+pop: count unchanged; allowed when full (pop frees slot same edge).
//  - Full, qin_v=1, no pop: token dropped, ovf set (sticky until reset), count stays DEPTH.
//  - Empty, qout_b ignored; no pop, no underflow.
//  - Pointers wrap DEPTH-1 -> 0 (explicit compare; no power-of-2 assumption).
//  - Count width clog2(DEPTH+1); pointer width clog2(DEPTH), min 1.
//  - eos_seen set on the edge a token with eos=1 pops; queue continues to accept later tokens.
// CONFIGURATION
//  PAGE_QIN_HWM_EN defined: adds output hwm [NCH*HWMW-1:0] (HWMW=clog2(DEPTH+1)), per-channel
//   high-water mark of count; updated next edge when count exceeds it; cleared by reset only.
//  Undefined: port and registers absent; all other behaviour identical.
// STRUCTURE
//  - Shared package page_qin_pkg.vh: clog2 function, token layout constants (EOS bit position = LSB,
//    token width W+1), RESERVE range check macro.
//  - Sub-module page_qin_chan: one-channel FIFO + counters + sticky flags; top instantiates NCH via
//    generate loop and slices buses.
//  - Elaboration-time check: RESERVE<DEPTH, DEPTH>=2, else $error/$finish.
// TESTING
//  1 W=16,NCH=1,DEPTH=4,RESERVE=1: push 0x1111..0x3333, qout_b=1 -> qin_b=1 after 3rd; 4th token
//    accepted, count=4; pop order 0x1111,0x2222,0x3333,0x4444.
//  2 Full (4 tokens), qin_v=1, qout_b=1 for 1 cycle -> ovf=1, count=4, data unchanged on pops.
//  3 Full, qin_v=1 and qout_b=0 same cycle -> pop 0x1111, push 0xAAAA, ovf stays 0; wrap order intact.
//  4 NCH=3,DEPTH=3: ch1 stalled (qout_b=1) while ch0/ch2 stream 100 tokens -> ch0/ch2 lossless, ch1 qin_b=1 only.
//  5 Token {0xBEEF,e=1} -> qout_e=1 one cycle after push; eos_seen=1 edge after pop; stays 1.
//  6 reset=0 asynchronously mid-transfer with 2 tokens queued -> qout_v=0, ovf=0, eos_seen=0
//    immediately; after release first push 0x5555 seen at qout next cycle; hwm=0 (if PAGE_QIN_HWM_EN).

Source files
------------

// File: rtl/page_qin_pkg.sv
// Shared definitions for the page input queue: clog2 helper, token layout,
// and the RESERVE range check macro.
`ifndef PAGE_QIN_PKG_SV
`define PAGE_QIN_PKG_SV

// True when the slack setting leaves at least one non-reserved slot.
`define PAGE_QIN_RESERVE_OK(depth, rsv) (((rsv) >= 0) && ((rsv) < (depth)))

package page_qin_pkg;

   // Token layout: {data, eos}. The eos flag sits in the LSB.
   localparam int EOS_POS = 0;

   function automatic int tokW(input int w);
      return w + 1;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

`endif

// File: rtl/page_qin_chan.sv
// One channel of the page input queue: DEPTH-entry FIFO with early busy,
// sticky overflow and eos-seen flags.
// Optional macro PAGE_QIN_HWM_EN adds a high-water-mark output.
module page_qin_chan
   import page_qin_pkg::*;
#(
   parameter int W       = 16,
   parameter int DEPTH   = 4,
   parameter int RESERVE = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [W-1:0]                qinD,
   input  logic                        qinE,
   input  logic                        qinV,
   output logic                        qinB,
   output logic [W-1:0]                qoutD,
   output logic                        qoutE,
   output logic                        qoutV,
   input  logic                        qoutB,
   output logic                        ovf,
   output logic                        eosSeen
`ifdef PAGE_QIN_HWM_EN
   ,
   output logic [clog2(DEPTH+1)-1:0]   hwm
`endif
);

   localparam int CW = clog2(DEPTH + 1);
   localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam int TW = tokW(W);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] BUSY_C  = CW'(DEPTH - RESERVE);
   localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

   logic [TW-1:0] mem [DEPTH];
   logic [PW-1:0] rdPtr, wrPtr;
   logic [CW-1:0] count;
   logic [TW-1:0] head;
   logic          push, pop;

   // Pointers wrap by explicit compare so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : PW'(p + 1'b1);
   endfunction

   assign head  = mem[rdPtr];
   assign qoutV = (count != '0);
   assign pop   = qoutV & ~qoutB;
   assign push  = qinV & ((count < DEPTH_C) | pop);
   assign qinB  = (count >= BUSY_C);
   assign qoutD = qoutV ? head[TW-1:1] : '0;
   assign qoutE = qoutV & head[EOS_POS];

   // Token storage; stale entries are masked on the output by qoutV.
   always_ff @(posedge clock) begin
      if (push) mem[wrPtr] <= {qinD, qinE};
   end

   // Pointers, occupancy and sticky status flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdPtr   <= '0;
         wrPtr   <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         eosSeen <= 1'b0;
      end else begin
         if (push) wrPtr <= nextPtr(wrPtr);
         if (pop)  rdPtr <= nextPtr(rdPtr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (qinV && (count == DEPTH_C) && !pop) ovf <= 1'b1;
         if (pop && head[EOS_POS]) eosSeen <= 1'b1;
      end
   end

`ifdef PAGE_QIN_HWM_EN
   // High-water mark trails count by one edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           hwm <= '0;
      else if (count > hwm) hwm <= count;
   end
`endif

endmodule

// File: rtl/page_qin_mchan.sv
// Multi-channel page input queue: NCH independent page_qin_chan instances.
// Optional macro PAGE_QIN_HWM_EN adds the per-channel hwm bus.
module page_qin_mchan
   import page_qin_pkg::*;
#(
   parameter int W       = 16,
   parameter int NCH     = 1,
   parameter int DEPTH   = 4,
   parameter int RESERVE = 1,
   localparam int HWMW   = clog2(DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NCH*W-1:0]    qin_d,
   input  logic [NCH-1:0]      qin_e,
   input  logic [NCH-1:0]      qin_v,
   output logic [NCH-1:0]      qin_b,
   output logic [NCH*W-1:0]    qout_d,
   output logic [NCH-1:0]      qout_e,
   output logic [NCH-1:0]      qout_v,
   input  logic [NCH-1:0]      qout_b,
   output logic [NCH-1:0]      ovf,
   output logic [NCH-1:0]      eos_seen
`ifdef PAGE_QIN_HWM_EN
   ,
   output logic [NCH*HWMW-1:0] hwm
`endif
);

   // Reject configurations with no usable slot or a degenerate FIFO.
   if (!`PAGE_QIN_RESERVE_OK(DEPTH, RESERVE) || DEPTH < 2) begin : gBadCfg
      $error("page_qin_mchan: need DEPTH>=2 and 0<=RESERVE<DEPTH");
   end

   // One queue per channel, buses sliced per channel index.
   for (genvar c = 0; c < NCH; c++) begin : gChan
      page_qin_chan #(
         .W       (W),
         .DEPTH   (DEPTH),
         .RESERVE (RESERVE)
      ) uChan (
         .clock   (clock),
         .reset   (reset),
         .qinD    (qin_d[c*W +: W]),
         .qinE    (qin_e[c]),
         .qinV    (qin_v[c]),
         .qinB    (qin_b[c]),
         .qoutD   (qout_d[c*W +: W]),
         .qoutE   (qout_e[c]),
         .qoutV   (qout_v[c]),
         .qoutB   (qout_b[c]),
         .ovf     (ovf[c]),
         .eosSeen (eos_seen[c])
`ifdef PAGE_QIN_HWM_EN
         ,
         .hwm     (hwm[c*HWMW +: HWMW])
`endif
      );
   end

endmodule

// File: tb/tb_page_qin_mchan.sv
// Self-checking bench for page_qin_mchan: directed steps plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_page_qin_mchan;
   import page_qin_pkg::*;

   localparam int W     = 16;
   localparam int NCH   = 3;
   localparam int DEPTH = 4;
   localparam int RES   = 1;
   localparam int HWMW  = clog2(DEPTH + 1);

   logic               clock = 1'b0;
   logic               reset;
   logic [NCH*W-1:0]   qin_d;
   logic [NCH-1:0]     qin_e, qin_v, qin_b;
   logic [NCH*W-1:0]   qout_d;
   logic [NCH-1:0]     qout_e, qout_v, qout_b, ovf, eos_seen;
`ifdef PAGE_QIN_HWM_EN
   logic [NCH*HWMW-1:0] hwm;
`endif

   page_qin_mchan #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .RESERVE(RES)) dut (
      .clock    (clock),
      .reset    (reset),
      .qin_d    (qin_d),
      .qin_e    (qin_e),
      .qin_v    (qin_v),
      .qin_b    (qin_b),
      .qout_d   (qout_d),
      .qout_e   (qout_e),
      .qout_v   (qout_v),
      .qout_b   (qout_b),
      .ovf      (ovf),
      .eos_seen (eos_seen)
`ifdef PAGE_QIN_HWM_EN
      ,
      .hwm      (hwm)
`endif
   );

   always #5 clock = ~clock;

   int nAssert = 0;
   int nFail   = 0;

   // Reference model: one token queue per channel plus sticky flags.
   logic [W:0] mq [NCH][$];
   bit         mOvf [NCH];
   bit         mEos [NCH];
   int         mHwm [NCH];
   int         nPush [NCH];
   int         nPop  [NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelClear();
      for (int c = 0; c < NCH; c++) begin
         mq[c].delete();
         mOvf[c] = 0;
         mEos[c] = 0;
         mHwm[c] = 0;
      end
   endtask

   task automatic checkAll();
      for (int c = 0; c < NCH; c++) begin
         int n;
         n = mq[c].size();
         chk($sformatf("qout_v[%0d]", c), 32'(qout_v[c]), 32'(n != 0));
         chk($sformatf("qout_d[%0d]", c), 32'(qout_d[c*W +: W]), (n != 0) ? 32'(mq[c][0][W:1]) : 32'd0);
         chk($sformatf("qout_e[%0d]", c), 32'(qout_e[c]), (n != 0) ? 32'(mq[c][0][0]) : 32'd0);
         chk($sformatf("qin_b[%0d]", c), 32'(qin_b[c]), 32'(n >= DEPTH - RES));
         chk($sformatf("ovf[%0d]", c), 32'(ovf[c]), 32'(mOvf[c]));
         chk($sformatf("eos_seen[%0d]", c), 32'(eos_seen[c]), 32'(mEos[c]));
`ifdef PAGE_QIN_HWM_EN
         chk($sformatf("hwm[%0d]", c), 32'(hwm[c*HWMW +: HWMW]), 32'(mHwm[c]));
`endif
      end
   endtask

   // One clock with the currently driven inputs; model follows the queue rules.
   task automatic step();
      bit         doPop  [NCH];
      bit         doPush [NCH];
      logic [W:0] tok    [NCH];
      for (int c = 0; c < NCH; c++) begin
         doPop[c]  = (mq[c].size() != 0) && !qout_b[c];
         doPush[c] = qin_v[c] && ((mq[c].size() < DEPTH) || doPop[c]);
         tok[c]    = {qin_d[c*W +: W], qin_e[c]};
         if (qin_v[c] && !doPush[c]) mOvf[c] = 1;
         if (mq[c].size() > mHwm[c]) mHwm[c] = mq[c].size();
      end
      @(posedge clock);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (doPop[c]) begin
            if (mq[c][0][0]) mEos[c] = 1;
            void'(mq[c].pop_front());
            nPop[c]++;
         end
         if (doPush[c]) begin
            mq[c].push_back(tok[c]);
            nPush[c]++;
         end
      end
      checkAll();
   endtask

   task automatic drv(input int c, input bit v, input logic [W-1:0] d, input bit e, input bit b);
      qin_v[c]         = v;
      qin_d[c*W +: W]  = d;
      qin_e[c]         = e;
      qout_b[c]        = b;
   endtask

   initial begin
      logic [W-1:0]   expOrd [4];
      logic [NCH-1:0] lagB;
      bit             busy02;
      int             budget;
      int             base0, base2;

      expOrd[0] = 16'h2222; expOrd[1] = 16'h3333;
      expOrd[2] = 16'h4444; expOrd[3] = 16'hAAAA;
      for (int c = 0; c < NCH; c++) begin
         nPush[c] = 0;
         nPop[c]  = 0;
      end

      // Reset state.
      reset  = 1'b0;
      qin_v  = '0;
      qin_d  = '0;
      qin_e  = '0;
      qout_b = '0;
      modelClear();
      #1;
      checkAll();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;

      // Ch1 stalled, ch0/ch2 stream 100 tokens with a one-cycle-late producer.
      lagB   = '0;
      busy02 = 0;
      base0  = nPush[0];
      base2  = nPush[2];
      budget = 0;
      qout_b = 3'b010;
      while ((nPush[0] - base0 < 100 || nPush[2] - base2 < 100) && budget < 3000) begin
         for (int c = 0; c < NCH; c++) begin
            qin_v[c]        = ($urandom_range(0, 3) != 0) && !lagB[c];
            qin_d[c*W +: W] = W'($urandom);
            qin_e[c]        = 1'b0;
         end
         lagB = qin_b;
         if (qin_b[0] || qin_b[2]) busy02 = 1;
         step();
         budget++;
      end
      chk("t4_stream_done0", 32'(nPush[0] - base0 >= 100), 32'd1);
      chk("t4_stream_done2", 32'(nPush[2] - base2 >= 100), 32'd1);
      chk("t4_busy_ch0_ch2", 32'(busy02), 32'd0);
      chk("t4_busy", 32'(qin_b), 32'b010);
      chk("t4_ovf", 32'(ovf), 32'd0);

      // Drain everything.
      qin_v  = '0;
      qout_b = '0;
      repeat (DEPTH + 1) step();
      chk("drain_v", 32'(qout_v), 32'd0);

      // Fill ch0 with the consumer stalled; busy after the third token.
      drv(0, 1, 16'h1111, 0, 1); step();
      drv(0, 1, 16'h2222, 0, 1); step();
      chk("t1_busy_after2", 32'(qin_b[0]), 32'd0);
      drv(0, 1, 16'h3333, 0, 1); step();
      chk("t1_busy_after3", 32'(qin_b[0]), 32'd1);
      drv(0, 1, 16'h4444, 0, 1); step();
      chk("t1_head", 32'(qout_d[15:0]), 32'h1111);

      // Full with simultaneous push and pop: no overflow.
      drv(0, 1, 16'hAAAA, 0, 0); step();
      chk("t3_ovf", 32'(ovf[0]), 32'd0);
      chk("t3_head", 32'(qout_d[15:0]), 32'h2222);

      // Full, offered token while stalled: dropped and ovf set.
      drv(0, 1, 16'h9999, 0, 1); step();
      chk("t2_ovf", 32'(ovf[0]), 32'd1);
      chk("t2_head", 32'(qout_d[15:0]), 32'h2222);

      // Pop order across the pointer wrap.
      drv(0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_order%0d", i), 32'(qout_d[15:0]), 32'(expOrd[i]));
         step();
      end
      chk("t3_empty", 32'(qout_v[0]), 32'd0);

      // EOS token on ch1.
      drv(1, 1, 16'hBEEF, 1, 1); step();
      chk("t5_qout_e", 32'(qout_e[1]), 32'd1);
      chk("t5_eos_before", 32'(eos_seen[1]), 32'd0);
      drv(1, 0, 16'h0, 0, 0); step();
      chk("t5_eos_after", 32'(eos_seen[1]), 32'd1);
      step();
      chk("t5_eos_sticky", 32'(eos_seen[1]), 32'd1);

      // Fully random traffic on all channels, overflow allowed.
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NCH; c++) begin
            drv(c, 1'($urandom), W'($urandom), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) != 0));
         end
         step();
      end

      // Async reset mid-transfer with two tokens queued on ch0.
      qin_v  = '0;
      qout_b = '1;
      repeat (DEPTH) step();
      qout_b = '0;
      repeat (DEPTH) step();
      drv(0, 1, 16'h0101, 0, 1); step();
      drv(0, 1, 16'h0202, 1, 1); step();
      drv(0, 1, 16'h0303, 0, 0);
      #3;
      reset = 1'b0;
      #1;
      modelClear();
      qin_v = '0;
      chk("t6_v", 32'(qout_v), 32'd0);
      chk("t6_ovf", 32'(ovf), 32'd0);
      chk("t6_eos", 32'(eos_seen), 32'd0);
`ifdef PAGE_QIN_HWM_EN
      chk("t6_hwm", 32'(hwm), 32'd0);
`endif
      checkAll();
      @(posedge clock);
      #1;
      reset = 1'b1;
      checkAll();
      drv(0, 1, 16'h5555, 0, 1); step();
      chk("t6_first", 32'(qout_d[15:0]), 32'h5555);
      chk("t6_first_v", 32'(qout_v[0]), 32'd1);
      drv(0, 0, 16'h0, 0, 0); step();

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
